// File: rtl/sc_road_pkg.sv
// ---------------------------------------------------------------------------
// sc_road_pkg
// Shared definitions for the road-state select interface between the game
// state machine and the road-row loader.
//   sel_t    : per-row select code (CLEAR / FILL / RANDOM / HOLD)
//   state_t  : loader FSM states
//   ROWS     : number of road rows held by the loader
//   LFSR_W   : width of the shared pseudo-random generator
//   LAST_IDX : row index of the final write in a load
// ---------------------------------------------------------------------------
package sc_road_pkg;

    localparam int unsigned ROWS   = 7;
    localparam int unsigned LFSR_W = 16;

    localparam logic [2:0] LAST_IDX = 3'(ROWS - 1);

    typedef enum logic [1:0] {
        SEL_CLEAR  = 2'd0,
        SEL_FILL   = 2'd1,
        SEL_RANDOM = 2'd2,
        SEL_HOLD   = 2'd3
    } sel_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sc_lfsr16.sv
// ---------------------------------------------------------------------------
// sc_lfsr16
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), shifting left on
// every rising clock edge. An all-zero state reloads the seed so the
// generator can never lock up.
// Ports:
//   clock       in   1   rising-edge clock
//   reset_InLow in   1   asynchronous active-low reset, loads LFSR_SEED
//   lfsr_state  out  16  current LFSR register value
// ---------------------------------------------------------------------------
module sc_lfsr16
    import sc_road_pkg::*;
#(
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clock,
    input  logic              reset_InLow,
    output logic [LFSR_W-1:0] lfsr_state
);

    logic feedback;

    assign feedback = lfsr_state[15] ^ lfsr_state[13] ^ lfsr_state[12] ^ lfsr_state[10];

    always_ff @(posedge clock or negedge reset_InLow) begin
        if (!reset_InLow) begin
            lfsr_state <= LFSR_SEED;
        end else if (lfsr_state == '0) begin
            lfsr_state <= LFSR_SEED;
        end else begin
            lfsr_state <= {lfsr_state[14:0], feedback};
        end
    end

endmodule

// File: rtl/sc_roadloader.sv
// ---------------------------------------------------------------------------
// sc_roadloader
// Consumer end of the road-state select interface. A load tick snapshots the
// seven per-row select codes; the rows are then written one per clock
// (row1..row7) and DONE pulses for one cycle. Each row is cleared, filled,
// loaded with LFSR data, or held according to its snapshotted code.
// Ports:
//   SC_ROADLOADER_CLOCK_50        in   1          system clock
//   SC_ROADLOADER_RESET_InLow     in   1          asynchronous active-low reset
//   SC_ROADLOADER_TICK_InHigh     in   1          load request pulse
//   SC_ROADLOADER_SEL1..7_InBUS   in   SELWIDTH   per-row select codes
//   SC_ROADLOADER_ROW1..7_OutBUS  out  DATAWIDTH  registered road rows
//   SC_ROADLOADER_BUSY_OutHigh    out  1          high while not idle
//   SC_ROADLOADER_DONE_OutHigh    out  1          one-cycle completion pulse
//   SC_ROADLOADER_OVERRUN_OutHigh out  1          sticky: tick arrived while busy
// ---------------------------------------------------------------------------
module sc_roadloader
    import sc_road_pkg::*;
#(
    parameter int unsigned       DATAWIDTH = 8,
    parameter int unsigned       SELWIDTH  = 2,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
    input  logic                 SC_ROADLOADER_CLOCK_50,
    input  logic                 SC_ROADLOADER_RESET_InLow,
    input  logic                 SC_ROADLOADER_TICK_InHigh,
    input  logic [SELWIDTH-1:0]  SC_ROADLOADER_SEL1_InBUS,
    input  logic [SELWIDTH-1:0]  SC_ROADLOADER_SEL2_InBUS,
    input  logic [SELWIDTH-1:0]  SC_ROADLOADER_SEL3_InBUS,
    input  logic [SELWIDTH-1:0]  SC_ROADLOADER_SEL4_InBUS,
    input  logic [SELWIDTH-1:0]  SC_ROADLOADER_SEL5_InBUS,
    input  logic [SELWIDTH-1:0]  SC_ROADLOADER_SEL6_InBUS,
    input  logic [SELWIDTH-1:0]  SC_ROADLOADER_SEL7_InBUS,
    output logic [DATAWIDTH-1:0] SC_ROADLOADER_ROW1_OutBUS,
    output logic [DATAWIDTH-1:0] SC_ROADLOADER_ROW2_OutBUS,
    output logic [DATAWIDTH-1:0] SC_ROADLOADER_ROW3_OutBUS,
    output logic [DATAWIDTH-1:0] SC_ROADLOADER_ROW4_OutBUS,
    output logic [DATAWIDTH-1:0] SC_ROADLOADER_ROW5_OutBUS,
    output logic [DATAWIDTH-1:0] SC_ROADLOADER_ROW6_OutBUS,
    output logic [DATAWIDTH-1:0] SC_ROADLOADER_ROW7_OutBUS,
    output logic                 SC_ROADLOADER_BUSY_OutHigh,
    output logic                 SC_ROADLOADER_DONE_OutHigh,
    output logic                 SC_ROADLOADER_OVERRUN_OutHigh
);

    logic clk;
    logic rst_n;

    assign clk   = SC_ROADLOADER_CLOCK_50;
    assign rst_n = SC_ROADLOADER_RESET_InLow;

    state_t                             state;
    logic [2:0]                         idx;
    logic [ROWS-1:0][SELWIDTH-1:0]      snap;
    logic [ROWS-1:0][DATAWIDTH-1:0]     rows;
    logic [ROWS-1:0]                    row_we;
    logic                               busy_q;
    logic                               done_q;
    logic                               overrun_q;
    logic [LFSR_W-1:0]                  lfsr;
    logic                               unused_lfsr;

    sc_lfsr16 #(
        .LFSR_SEED (LFSR_SEED)
    ) u_lfsr (
        .clock       (clk),
        .reset_InLow (rst_n),
        .lfsr_state  (lfsr)
    );

    // Only the low DATAWIDTH bits feed the rows; the rest advance the sequence.
    assign unused_lfsr = ^lfsr;

    // ------------------------------------------------------------------
    // Control FSM: snapshot, row index, and registered status outputs.
    // BUSY/DONE are registered alongside the state so they track it
    // cycle-for-cycle without output decoding.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            snap      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (SC_ROADLOADER_TICK_InHigh) begin
                        snap   <= {SC_ROADLOADER_SEL7_InBUS, SC_ROADLOADER_SEL6_InBUS,
                                   SC_ROADLOADER_SEL5_InBUS, SC_ROADLOADER_SEL4_InBUS,
                                   SC_ROADLOADER_SEL3_InBUS, SC_ROADLOADER_SEL2_InBUS,
                                   SC_ROADLOADER_SEL1_InBUS};
                        idx    <= '0;
                        state  <= ST_LOAD;
                        busy_q <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (SC_ROADLOADER_TICK_InHigh) begin
                        overrun_q <= 1'b1;
                    end
                    if (idx == LAST_IDX) begin
                        idx    <= '0;
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                ST_DONE: begin
                    if (SC_ROADLOADER_TICK_InHigh) begin
                        overrun_q <= 1'b1;
                    end
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Row register bank: one write enable per row, decoded from idx.
    // ------------------------------------------------------------------
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [DATAWIDTH-1:0] row_q;
        logic [DATAWIDTH-1:0] row_nxt;

        assign row_we[r] = (state == ST_LOAD) && (idx == 3'(r));

        always_comb begin
            row_nxt = row_q;
            case (sel_t'(snap[r]))
                SEL_CLEAR:  row_nxt = '0;
                SEL_FILL:   row_nxt = '1;
                SEL_RANDOM: row_nxt = lfsr[DATAWIDTH-1:0];
                default:    row_nxt = row_q;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                row_q <= '0;
            end else if (row_we[r]) begin
                row_q <= row_nxt;
            end
        end

        assign rows[r] = row_q;
    end

    assign SC_ROADLOADER_ROW1_OutBUS     = rows[0];
    assign SC_ROADLOADER_ROW2_OutBUS     = rows[1];
    assign SC_ROADLOADER_ROW3_OutBUS     = rows[2];
    assign SC_ROADLOADER_ROW4_OutBUS     = rows[3];
    assign SC_ROADLOADER_ROW5_OutBUS     = rows[4];
    assign SC_ROADLOADER_ROW6_OutBUS     = rows[5];
    assign SC_ROADLOADER_ROW7_OutBUS     = rows[6];
    assign SC_ROADLOADER_BUSY_OutHigh    = busy_q;
    assign SC_ROADLOADER_DONE_OutHigh    = done_q;
    assign SC_ROADLOADER_OVERRUN_OutHigh = overrun_q;

endmodule

// File: tb/tb_sc_roadloader.sv
// ---------------------------------------------------------------------------
// tb_sc_roadloader
// Directed bench for sc_roadloader: expected row values are pushed to a
// queue when a load is requested and popped as each row is written.
// ---------------------------------------------------------------------------
module tb_sc_roadloader;

    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick  = 1'b0;
    logic [1:0] sel  [7];
    logic [7:0] row  [7];
    logic       busy;
    logic       done;
    logic       ovr;

    int errors = 0;
    int checks = 0;

    logic [7:0]  exp_row [7];
    logic [7:0]  old_row [7];
    logic [7:0]  sbq [$];
    logic [15:0] m;
    logic        exp_ovr;

    always #5 clk = ~clk;

    sc_roadloader #(
        .DATAWIDTH (8),
        .SELWIDTH  (2),
        .LFSR_SEED (SEED)
    ) dut (
        .SC_ROADLOADER_CLOCK_50        (clk),
        .SC_ROADLOADER_RESET_InLow     (rst_n),
        .SC_ROADLOADER_TICK_InHigh     (tick),
        .SC_ROADLOADER_SEL1_InBUS      (sel[0]),
        .SC_ROADLOADER_SEL2_InBUS      (sel[1]),
        .SC_ROADLOADER_SEL3_InBUS      (sel[2]),
        .SC_ROADLOADER_SEL4_InBUS      (sel[3]),
        .SC_ROADLOADER_SEL5_InBUS      (sel[4]),
        .SC_ROADLOADER_SEL6_InBUS      (sel[5]),
        .SC_ROADLOADER_SEL7_InBUS      (sel[6]),
        .SC_ROADLOADER_ROW1_OutBUS     (row[0]),
        .SC_ROADLOADER_ROW2_OutBUS     (row[1]),
        .SC_ROADLOADER_ROW3_OutBUS     (row[2]),
        .SC_ROADLOADER_ROW4_OutBUS     (row[3]),
        .SC_ROADLOADER_ROW5_OutBUS     (row[4]),
        .SC_ROADLOADER_ROW6_OutBUS     (row[5]),
        .SC_ROADLOADER_ROW7_OutBUS     (row[6]),
        .SC_ROADLOADER_BUSY_OutHigh    (busy),
        .SC_ROADLOADER_DONE_OutHigh    (done),
        .SC_ROADLOADER_OVERRUN_OutHigh (ovr)
    );

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        if (s == 16'h0000) return SEED;
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Reference LFSR: m holds the value the DUT will sample at the next edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= SEED;
        else        m <= lfsr_next(m);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Asynchronous reset between edges, checked before the next edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        tick  = 1'b0;
        #1;
        for (int k = 0; k < 7; k++) chk($sformatf("%s_row%0d", tag, k + 1), 32'(row[k]), 32'h00);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_ovr"},  32'(ovr),  32'd0);
        chk({tag, "_lfsr"}, 32'(dut.u_lfsr.lfsr_state), 32'(SEED));
        for (int k = 0; k < 7; k++) exp_row[k] = 8'h00;
        sbq.delete();
        exp_ovr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive selects and a one-cycle tick; push the expected row sequence.
    task automatic start_load(input logic [1:0] s [7]);
        logic [15:0] r;
        r = m;
        for (int k = 0; k < 7; k++) begin
            sel[k]     = s[k];
            old_row[k] = exp_row[k];
            r = lfsr_next(r);
            case (s[k])
                2'd0:    exp_row[k] = 8'h00;
                2'd1:    exp_row[k] = 8'hFF;
                2'd2:    exp_row[k] = r[7:0];
                default: exp_row[k] = exp_row[k];
            endcase
            sbq.push_back(exp_row[k]);
        end
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        chk("busy_after_tick", 32'(busy), 32'd1);
        chk("done_after_tick", 32'(done), 32'd0);
    endtask

    // Follow a load cycle by cycle. t1/t2: cycles (after edge T+k) in which a
    // stray tick is driven; chg: cycle after which all selects become nsel.
    task automatic run_load(input int t1, input int t2, input int chg, input logic [1:0] nsel);
        logic [7:0] e;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (sbq.size() == 0) begin
                chk($sformatf("sb_empty_row%0d", k), 32'd1, 32'd0);
                e = 8'h00;
            end else begin
                e = sbq.pop_front();
            end
            chk($sformatf("row%0d_at_T+%0d", k, k), 32'(row[k-1]), 32'(e));
            if (k < 7) chk($sformatf("row%0d_early", k + 1), 32'(row[k]), 32'(old_row[k]));
            chk($sformatf("done_at_T+%0d", k), 32'(done), 32'(k == 7));
            chk($sformatf("busy_at_T+%0d", k), 32'(busy), 32'd1);
            if (k == t1 || k == t2) begin
                tick    = 1'b1;
                exp_ovr = 1'b1;
            end else begin
                tick = 1'b0;
            end
            if (k == chg) for (int j = 0; j < 7; j++) sel[j] = nsel;
        end
        @(negedge clk);
        tick = 1'b0;
        chk("done_after_load", 32'(done), 32'd0);
        chk("busy_after_load", 32'(busy), 32'd0);
        chk("ovr_after_load",  32'(ovr),  32'(exp_ovr));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] s [7];
        for (int k = 0; k < 7; k++) begin
            sel[k]     = 2'd0;
            exp_row[k] = 8'h00;
            old_row[k] = 8'h00;
        end
        exp_ovr = 1'b0;
        repeat (3) @(negedge clk);

        // Initial reset state
        do_reset("rst0");

        // T1: reset in the middle of a FILL load
        s = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
        start_load(s);
        repeat (3) @(negedge clk);
        chk("t1_row1_before_rst", 32'(row[0]), 32'hFF);
        do_reset("t1");

        // T3: all RANDOM, tick sampled at the 10th edge after reset release
        repeat (9) @(negedge clk);
        s = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
        start_load(s);
        run_load(0, 0, 0, 2'd0);
        chk("t3_row1_const", 32'(row[0]), 32'h91);
        chk("t3_row7_const", 32'(row[6]), 32'h55);
        for (int i = 0; i < 7; i++)
            for (int j = i + 1; j < 7; j++)
                chk($sformatf("t3_distinct_%0d_%0d", i + 1, j + 1), 32'(row[i] == row[j]), 32'd0);

        // T2: mixed selects over the random preset (HOLD keeps rows 3 and 6)
        s = '{2'd0, 2'd1, 2'd3, 2'd1, 2'd0, 2'd3, 2'd1};
        start_load(s);
        run_load(0, 0, 0, 2'd0);
        chk("t2_row3_held", 32'(row[2]), 32'h45);
        chk("t2_row6_held", 32'(row[5]), 32'h2A);

        // T4: selects edited mid-load must not affect the snapshot
        s = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
        start_load(s);
        run_load(0, 0, 2, 2'd0);

        // T5: stray ticks at T+3 and in the DONE cycle, then an accepted tick
        s = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0};
        start_load(s);
        run_load(3, 7, 0, 2'd0);
        s = '{2'd1, 2'd0, 2'd1, 2'd3, 2'd2, 2'd0, 2'd1};
        start_load(s);
        run_load(0, 0, 0, 2'd0);
        chk("t5_ovr_sticky", 32'(ovr), 32'd1);

        // T6: 20 back-to-back loads at the minimum period, then abort
        do_reset("t6_pre");
        repeat (2) @(negedge clk);
        for (int n = 0; n < 20; n++) begin
            for (int k = 0; k < 7; k++) s[k] = 2'($urandom_range(0, 3));
            start_load(s);
            run_load(0, 0, 0, 2'd0);
        end
        chk("t6_no_overrun", 32'(ovr), 32'd0);
        s = '{2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1};
        start_load(s);
        repeat (3) @(negedge clk);
        do_reset("t6_abort");
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk($sformatf("t6_no_done_%0d", c), 32'(done), 32'd0);
            chk($sformatf("t6_idle_%0d", c), 32'(busy), 32'd0);
        end
        chk("t6_row1_cleared", 32'(row[0]), 32'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
